secure_access_arbiter: RTL and testbench
========================================

Name: secure_access_arbiter

Overview:
- Shares one password-protected even/odd enable resource among NREQ requesters.
- Grants round-robin and checks each requester's password against the stored passedData on confirm.
- On a match, drives evenEnable/oddEnable from the requester's sampled d. On a mismatch, counts the failure.
- A requester with MAX_FAIL consecutive failures is locked out for LOCK_CYCLES.

Parameters:
- NREQ, 4, number of requesters.
- DW, 4, width of password, passedData and d.
- MAX_FAIL, 3, consecutive failures that trigger lockout.
- LOCK_CYCLES, 8, lockout duration in clk cycles.
- CONF_TIMEOUT, 6, cycles a granted requester may wait before confirm counts as a failure.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- passedData  in  DW  stored password; compared combinationally, stable during operation.
- req  in  NREQ  per-requester access request, level.
- confirm  in  NREQ  per-requester confirm, sampled only while granted.
- password  in  NREQ*DW  packed; slice i = requester i password.
- d  in  NREQ*DW  packed; slice i = requester i data; bit 0 selects odd/even.
- grant  out  NREQ  one-hot current owner, all-zero when idle.
- evenEnable  out  1  resource enabled, data even.
- oddEnable  out  1  resource enabled, data odd.
- denied  out  1  one-cycle pulse on a failed check or timeout.
- locked  out  NREQ  requester i currently locked out.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; grant=0, evenEnable=0, oddEnable=0, denied=0, locked=0.
  - All fail counters and lock timers cleared; round-robin pointer=0 (requester 0 has highest priority first).
- All outputs are registered.
- States: IDLE, GRANT, SERVE.
- IDLE:
  - Eligible = req & ~locked.
  - If any are eligible, pick the first eligible index at or after ptr (wrapping), set grant, go to GRANT.
  - Latency req→grant is 1 cycle.
- GRANT (owner g):
  - Wait counter starts at 0.
  - req[g]=0: release the grant, go to IDLE. No failure counted.
  - confirm[g]=1 and password[g]==passedData:
    - Latch d[g]; next cycle evenEnable=~d[g][0], oddEnable=d[g][0].
    - failCnt[g]=0; go to SERVE.
    - Latency confirm→enable is 1 cycle.
  - confirm[g]=1 with a mismatch, or wait counter reaching CONF_TIMEOUT:
    - denied=1 for one cycle; failCnt[g]+1; grant=0; go to IDLE; ptr=g+1.
  - confirm[j], j≠g, is ignored.
- SERVE:
  - Enables and grant hold while req[g]=1.
  - Changes to d or confirm are ignored; d is latched.
  - req[g]=0: next cycle enables=0 and grant=0, state=IDLE, ptr=g+1 mod NREQ.
- Lockout:
  - When failCnt[g] reaches MAX_FAIL, locked[g]=1 in the same cycle as the denied pulse, and the lock timer is loaded with LOCK_CYCLES.
  - The timer decrements every cycle. On reaching 0, locked[g]=0 and failCnt[g]=0.
  - Each requester's timer runs independently and keeps running while others are served.
  - A locked requester is never granted, even if it is the only requester.
- Fail counter saturates at MAX_FAIL.
- Simultaneous requests: only the round-robin winner is granted; others keep waiting, with no starvation.
- Reset mid-SERVE: enables drop immediately (async). Lockouts are cleared.
- evenEnable and oddEnable are never both 1. grant is always one-hot or zero.

Decomposition:
- Shared package:
  - state enum (IDLE, GRANT, SERVE);
  - default constants MAX_FAIL, LOCK_CYCLES, CONF_TIMEOUT;
  - helper function for the round-robin search.
- One sub-module, access_lock_tracker, instantiated per requester. It holds the fail counter and lock timer, with inputs fail_pulse and success_pulse and output locked.

Test Plan:
- passedData=1010, req0=1, password0=1010, confirm0 one cycle after grant, d0=0001 → grant=0001 one cycle after req; oddEnable=1 one cycle after confirm; cleared one cycle after req0 drops.
- Same flow with d0=0000 → evenEnable=1, oddEnable=0. Changing d0 to 0011 during SERVE leaves evenEnable=1.
- req0 with password0=1000 confirmed three times → denied pulses ×3. After the third, locked[0]=1 for 8 cycles. A req0 during lockout gets no grant; after expiry, the correct password is granted.
- req=1111 held, each requester confirms correctly, then releases → grants in order 0001, 0010, 0100, 1000, 0001.
- req1=1, never confirms → denied pulse after 6 cycles in GRANT; failCnt1=1. A later correct access resets it to 0.
- rst_n pulsed low during SERVE with oddEnable=1 → oddEnable, grant, locked drop immediately; after release the block is in IDLE with ptr=0.

Source files
------------

// File: rtl/secure_access_arbiter_pkg.sv
// Shared types, default limits and the round-robin search used by the
// secure access arbiter and its per-requester lock trackers.
package secure_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam int DEF_MAX_FAIL     = 3;
    localparam int DEF_LOCK_CYCLES  = 8;
    localparam int DEF_CONF_TIMEOUT = 6;
    localparam int RR_MAX           = 32;

    // First set index at or after ptr (wrapping modulo n), or -1 when none is set.
    function automatic int rr_pick(input logic [RR_MAX-1:0] eligible, input int ptr, input int n);
        int idx;
        rr_pick = -1;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (eligible[idx]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/access_lock_tracker.sv
// Per-requester consecutive-failure counter and lockout timer.
module access_lock_tracker
    import secure_access_arbiter_pkg::*;
#(
    parameter int MAX_FAIL    = DEF_MAX_FAIL,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fail_pulse,
    input  logic success_pulse,
    output logic locked
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);

    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] lock_timer;

    // Lockout expiry also forgives the accumulated failures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt   <= '0;
            lock_timer <= '0;
            locked     <= 1'b0;
        end else if (locked) begin
            if (lock_timer <= TW'(1)) begin
                locked     <= 1'b0;
                lock_timer <= '0;
                fail_cnt   <= '0;
            end else begin
                lock_timer <= lock_timer - 1'b1;
            end
        end else if (fail_pulse) begin
            if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
                fail_cnt   <= FW'(MAX_FAIL);
                locked     <= 1'b1;
                lock_timer <= TW'(LOCK_CYCLES);
            end else begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end else if (success_pulse) begin
            fail_cnt <= '0;
        end
    end

endmodule

// File: rtl/secure_access_arbiter.sv
// Round-robin arbiter granting a password-protected even/odd enable resource,
// with per-requester failure lockout.
module secure_access_arbiter
    import secure_access_arbiter_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DW           = 4,
    parameter int MAX_FAIL     = DEF_MAX_FAIL,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int CONF_TIMEOUT = DEF_CONF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      passedData,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    confirm,
    input  logic [NREQ*DW-1:0] password,
    input  logic [NREQ*DW-1:0] d,
    output logic [NREQ-1:0]    grant,
    output logic               evenEnable,
    output logic               oddEnable,
    output logic               denied,
    output logic [NREQ-1:0]    locked
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(CONF_TIMEOUT + 1);

    state_t            state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     next_ptr;
    logic [IW-1:0]     pick_idx;
    logic [WW-1:0]     wait_cnt;
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   pick_onehot;
    logic [NREQ-1:0]   fail_vec;
    logic [NREQ-1:0]   success_vec;
    logic [RR_MAX-1:0] elig_ext;
    logic [DW-1:0]     owner_pw;
    int                pick;
    logic              owner_req;
    logic              owner_conf;
    logic              owner_d0;
    logic              pw_match;
    logic              timeout;
    logic              in_grant;
    logic              fail_now;
    logic              success_now;
    logic              unused_d_bits;

    // Only bit 0 of each data slice matters; the rest are deliberately ignored.
    assign unused_d_bits = ^d;

    always_comb begin
        eligible          = req & ~locked;
        elig_ext          = '0;
        elig_ext[NREQ-1:0] = eligible;
        pick              = rr_pick(elig_ext, int'(ptr), NREQ);
        pick_idx          = pick[IW-1:0];
        pick_onehot       = '0;
        if (pick >= 0) pick_onehot[pick_idx] = 1'b1;

        owner_req   = req[owner];
        owner_conf  = confirm[owner];
        owner_pw    = password[owner*DW +: DW];
        owner_d0    = d[owner*DW];
        pw_match    = (owner_pw == passedData);
        timeout     = (wait_cnt >= WW'(CONF_TIMEOUT - 1));
        in_grant    = (state == GRANT);
        success_now = in_grant && owner_req && owner_conf && pw_match;
        fail_now    = in_grant && owner_req &&
                      ((owner_conf && !pw_match) || (!owner_conf && timeout));

        fail_vec    = '0;
        success_vec = '0;
        if (fail_now)    fail_vec[owner]    = 1'b1;
        if (success_now) success_vec[owner] = 1'b1;

        next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            evenEnable <= 1'b0;
            oddEnable  <= 1'b0;
            denied     <= 1'b0;
            owner      <= '0;
            ptr        <= '0;
            wait_cnt   <= '0;
        end else begin
            denied <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick >= 0) begin
                        grant    <= pick_onehot;
                        owner    <= pick_idx;
                        wait_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        grant <= '0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else if (success_now) begin
                        evenEnable <= ~owner_d0;
                        oddEnable  <= owner_d0;
                        state      <= SERVE;
                    end else if (fail_now) begin
                        denied <= 1'b1;
                        grant  <= '0;
                        ptr    <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SERVE: begin
                    if (!owner_req) begin
                        grant      <= '0;
                        evenEnable <= 1'b0;
                        oddEnable  <= 1'b0;
                        ptr        <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: begin
                    grant      <= '0;
                    evenEnable <= 1'b0;
                    oddEnable  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_trk
        access_lock_tracker #(
            .MAX_FAIL    (MAX_FAIL),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_trk (
            .clk           (clk),
            .rst_n         (rst_n),
            .fail_pulse    (fail_vec[i]),
            .success_pulse (success_vec[i]),
            .locked        (locked[i])
        );
    end

endmodule

// File: tb/tb_secure_access_arbiter.sv
// Directed self-checking bench for secure_access_arbiter with hand-computed
// expectations for access, lockout, round-robin, timeout and reset behaviour.
module tb_secure_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  passedData;
    logic [3:0]  req;
    logic [3:0]  confirm;
    logic [15:0] password;
    logic [15:0] d;
    logic [3:0]  grant;
    logic        evenEnable;
    logic        oddEnable;
    logic        denied;
    logic [3:0]  locked;

    int checks = 0;
    int fails  = 0;

    secure_access_arbiter #(
        .NREQ(4), .DW(4), .MAX_FAIL(3), .LOCK_CYCLES(8), .CONF_TIMEOUT(6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .passedData (passedData),
        .req        (req),
        .confirm    (confirm),
        .password   (password),
        .d          (d),
        .grant      (grant),
        .evenEnable (evenEnable),
        .oddEnable  (oddEnable),
        .denied     (denied),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        confirm = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        passedData = 4'b1010;
        password   = 16'h0000;
        d          = 16'h0000;
        do_reset();
        checks++;
        if ({grant, evenEnable, oddEnable, denied, locked} !== 11'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {grant, evenEnable, oddEnable, denied, locked}, 11'b0);
        end
        step();
        checks++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL idle_no_grant: got %b expected 0000", grant);
        end
    endtask

    task automatic test_odd_access();
        password[3:0] = 4'b1010;
        d[3:0]        = 4'b0001;
        req           = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001 || oddEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL odd_grant: got grant=%b odd=%b expected 0001 0", grant, oddEnable);
        end
        confirm = 4'b0001;
        step();
        confirm = 4'b0000;
        checks++;
        if (oddEnable !== 1'b1 || evenEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL odd_enable: got even=%b odd=%b expected 0 1", evenEnable, oddEnable);
        end
        step();
        checks++;
        if (oddEnable !== 1'b1 || grant !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL odd_hold: got odd=%b grant=%b expected 1 0001", oddEnable, grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (oddEnable !== 1'b0 || grant !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL odd_release: got odd=%b grant=%b expected 0 0000", oddEnable, grant);
        end
    endtask

    task automatic test_even_hold();
        d[3:0] = 4'b0000;
        req    = 4'b0001;
        step();
        confirm = 4'b0001;
        step();
        confirm = 4'b0000;
        checks++;
        if (evenEnable !== 1'b1 || oddEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL even_enable: got even=%b odd=%b expected 1 0", evenEnable, oddEnable);
        end
        d[3:0]  = 4'b0011;
        confirm = 4'b0001;
        step();
        step();
        confirm = 4'b0000;
        checks++;
        if (evenEnable !== 1'b1 || oddEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL even_data_latched: got even=%b odd=%b expected 1 0", evenEnable, oddEnable);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_lockout();
        password[3:0] = 4'b1000;
        req           = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (grant !== 4'b0001 || denied !== 1'b0) begin
                fails++;
                $display("[TB] FAIL lock_try%0d_grant: got grant=%b denied=%b expected 0001 0", k, grant, denied);
            end
            confirm = 4'b0001;
            step();
            confirm = 4'b0000;
            checks++;
            if (denied !== 1'b1 || grant !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL lock_try%0d_denied: got denied=%b grant=%b expected 1 0000", k, denied, grant);
            end
            checks++;
            if (locked !== ((k == 2) ? 4'b0001 : 4'b0000)) begin
                fails++;
                $display("[TB] FAIL lock_try%0d_locked: got %b expected %b", k, locked,
                         (k == 2) ? 4'b0001 : 4'b0000);
            end
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if (locked !== 4'b0001 || grant !== 4'b0000 || denied !== 1'b0) begin
                fails++;
                $display("[TB] FAIL lock_hold_c%0d: got locked=%b grant=%b denied=%b expected 0001 0000 0",
                         c, locked, grant, denied);
            end
        end
        step();
        checks++;
        if (locked !== 4'b0000 || grant !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL lock_expire: got locked=%b grant=%b expected 0000 0000", locked, grant);
        end
        password[3:0] = 4'b1010;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL lock_regrant: got %b expected 0001", grant);
        end
        confirm = 4'b0001;
        step();
        confirm = 4'b0000;
        checks++;
        if (oddEnable !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lock_after_access: got odd=%b expected 1", oddEnable);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        password = {4'b1010, 4'b1010, 4'b1010, 4'b1010};
        d        = 16'h0000;
        req      = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (grant !== order[n]) begin
                fails++;
                $display("[TB] FAIL rr_grant%0d: got %b expected %b", n, grant, order[n]);
            end
            confirm = order[n];
            step();
            confirm = 4'b0000;
            checks++;
            if (evenEnable !== 1'b1 || grant !== order[n]) begin
                fails++;
                $display("[TB] FAIL rr_serve%0d: got even=%b grant=%b expected 1 %b", n, evenEnable, grant, order[n]);
            end
            req = 4'b1111 & ~order[n];
            step();
            checks++;
            if (grant !== 4'b0000 || evenEnable !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rr_release%0d: got grant=%b even=%b expected 0000 0", n, grant, evenEnable);
            end
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_timeout();
        password[7:4] = 4'b1010;
        d[7:4]        = 4'b0000;
        req           = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL to_grant: got %b expected 0010", grant);
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || denied !== 1'b0) begin
                fails++;
                $display("[TB] FAIL to_wait_c%0d: got grant=%b denied=%b expected 0010 0", c, grant, denied);
            end
        end
        step();
        checks++;
        if (denied !== 1'b1 || grant !== 4'b0000 || locked !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL to_denied: got denied=%b grant=%b locked=%b expected 1 0000 0000",
                     denied, grant, locked);
        end
        step();
        confirm = 4'b0010;
        step();
        confirm = 4'b0000;
        checks++;
        if (evenEnable !== 1'b1 || grant !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL to_recover: got even=%b grant=%b expected 1 0010", evenEnable, grant);
        end
        req = 4'b0000;
        step();
        // Two fresh failures must not lock if the earlier timeout was forgiven.
        password[7:4] = 4'b1000;
        req           = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            step();
            confirm = 4'b0010;
            step();
            confirm = 4'b0000;
            checks++;
            if (denied !== 1'b1) begin
                fails++;
                $display("[TB] FAIL to_refail%0d: got denied=%b expected 1", k, denied);
            end
        end
        checks++;
        if (locked !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL to_count_cleared: got locked=%b expected 0000", locked);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_serve();
        do_reset();
        password = {4'b1010, 4'b1010, 4'b1000, 4'b1010};
        d        = {4'b0000, 4'b0001, 4'b0000, 4'b0000};
        req      = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            confirm = 4'b0010;
            step();
            confirm = 4'b0000;
        end
        checks++;
        if (locked !== 4'b0010 || denied !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rs_lock1: got locked=%b denied=%b expected 0010 1", locked, denied);
        end
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL rs_grant2: got %b expected 0100", grant);
        end
        confirm = 4'b0100;
        step();
        confirm = 4'b0000;
        checks++;
        if (oddEnable !== 1'b1 || locked !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL rs_serve2: got odd=%b locked=%b expected 1 0010", oddEnable, locked);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (oddEnable !== 1'b0 || grant !== 4'b0000 || locked !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL rs_async_drop: got odd=%b grant=%b locked=%b expected 0 0000 0000",
                     oddEnable, grant, locked);
        end
        step();
        rst_n = 1'b1;
        req   = 4'b0101;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL rs_ptr_zero: got %b expected 0001", grant);
        end
        confirm = 4'b0001;
        step();
        confirm = 4'b0000;
        checks++;
        if (evenEnable !== 1'b1 || oddEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rs_after_reset: got even=%b odd=%b expected 1 0", evenEnable, oddEnable);
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 4'b0000;
        confirm    = 4'b0000;
        passedData = 4'b1010;
        password   = 16'h0000;
        d          = 16'h0000;
        test_reset();
        test_odd_access();
        test_even_hold();
        test_lockout();
        test_round_robin();
        test_timeout();
        test_reset_serve();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
